framing_send_arb: RTL and testbench

FRAMING_SEND_ARB -- requirements
Module: framing_send_arb

---
 rtl/framing_send_arb_if.sv | 40 ++++
 rtl/framing_send_arb.sv | 157 +++++++++++++++
 tb/tb_framing_send_arb.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/framing_send_arb_if.sv
// rtl/framing_send_arb_if.sv - requester and framing-send bundle for framing_send_arb
// Purpose: carries the requester handshakes, the ring and length-FIFO write paths
//          and the sticky error/clear pair between the arbiter and its neighbours.
// Ports:   slave  - arbiter side (framing_send_arb)
//          master - requester / framing-block side
interface framing_send_arb_if #(
  parameter int NREQ     = 4,
  parameter int LEN_BITS = 8
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ*LEN_BITS-1:0] req_len;
  logic [NREQ*8-1:0]        req_data;
  logic [NREQ-1:0]          req_data_valid;
  logic [NREQ-1:0]          req_data_ack;
  logic [NREQ-1:0]          req_done;
  logic                     req_err;
  logic [NREQ-1:0]          grant;
  logic [7:0]               send_ring_data;
  logic                     send_ring_wr_en;
  logic                     send_ring_full;
  logic [LEN_BITS-1:0]      send_fifo_data;
  logic                     send_fifo_wr_en;
  logic                     send_fifo_full;
  logic                     error;
  logic                     clr;

  modport slave (
    input  req_valid, req_len, req_data, req_data_valid,
    input  send_ring_full, send_fifo_full, clr,
    output req_data_ack, req_done, req_err, grant,
    output send_ring_data, send_ring_wr_en, send_fifo_data, send_fifo_wr_en, error
  );

  modport master (
    output req_valid, req_len, req_data, req_data_valid,
    output send_ring_full, send_fifo_full, clr,
    input  req_data_ack, req_done, req_err, grant,
    input  send_ring_data, send_ring_wr_en, send_fifo_data, send_fifo_wr_en, error
  );
endinterface

// File: rtl/framing_send_arb.sv
// rtl/framing_send_arb.sv - round-robin arbiter serializing whole messages into the framing send path
// Purpose: grants one requester at a time, copies its payload bytes into the send
//          ring, then pushes the payload length into the length FIFO.
// Ports:   clk, rst_n - clock and asynchronous active-low reset
//          bus        - framing_send_arb_if.slave (requesters, ring, length FIFO, error/clr)
module framing_send_arb #(
  parameter int NREQ        = 4,
  parameter int LEN_BITS    = 8,
  parameter int MAX_PAYLOAD = 58
) (
  input logic               clk,
  input logic               rst_n,
  framing_send_arb_if.slave bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, COPY, COMMIT, REJECT} state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_owner_q, last_owner_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] remaining_q, remaining_d;
  logic                error_q, error_d;

  logic                found;
  logic [IDX_W-1:0]    pick;
  logic [LEN_BITS-1:0] pick_len;
  logic                own_dv;
  logic [7:0]          own_data;
  int                  scan_idx;

  logic [NREQ-1:0]     data_ack;
  logic [NREQ-1:0]     done;
  logic                err;
  logic                ring_wr;
  logic                fifo_wr;

  // Round-robin scan starting just after the last owner.
  always_comb begin
    found    = 1'b0;
    pick     = last_owner_q;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(last_owner_q) + 1 + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!found && (i == scan_idx) && bus.req_valid[i]) begin
          found = 1'b1;
          pick  = IDX_W'(i);
        end
      end
    end
  end

  // Slice muxes for the candidate's length and the owner's byte stream.
  always_comb begin
    pick_len = '0;
    own_dv   = 1'b0;
    own_data = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == pick) pick_len = bus.req_len[i*LEN_BITS +: LEN_BITS];
      if (IDX_W'(i) == owner_q) begin
        own_dv   = bus.req_data_valid[i];
        own_data = bus.req_data[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    len_d        = len_q;
    remaining_d  = remaining_q;
    // Clear first so that a rejection in the same cycle overrides it.
    error_d      = bus.clr ? 1'b0 : error_q;
    data_ack     = '0;
    done         = '0;
    err          = 1'b0;
    ring_wr      = 1'b0;
    fifo_wr      = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d     = NREQ'(1) << pick;
          owner_d     = pick;
          len_d       = pick_len;
          remaining_d = pick_len;
          if (int'(pick_len) > MAX_PAYLOAD) state_d = REJECT;
          else if (pick_len == '0)          state_d = COMMIT;
          else                              state_d = COPY;
        end
      end
      COPY: begin
        // req_valid is deliberately not consulted here: a granted message always runs to completion.
        if (own_dv && !bus.send_ring_full) begin
          ring_wr     = 1'b1;
          data_ack    = grant_q;
          remaining_d = remaining_q - LEN_BITS'(1);
          if (remaining_q == LEN_BITS'(1)) state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (!bus.send_fifo_full) begin
          fifo_wr      = 1'b1;
          done         = grant_q;
          last_owner_d = owner_q;
          grant_d      = '0;
          state_d      = IDLE;
        end
      end
      REJECT: begin
        done         = grant_q;
        err          = 1'b1;
        error_d      = 1'b1;
        last_owner_d = owner_q;
        grant_d      = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NREQ - 1);
      len_q        <= '0;
      remaining_q  <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      len_q        <= len_d;
      remaining_q  <= remaining_d;
      error_q      <= error_d;
    end
  end

  assign bus.req_data_ack    = data_ack;
  assign bus.req_done        = done;
  assign bus.req_err         = err;
  assign bus.grant           = grant_q;
  assign bus.send_ring_data  = own_data;
  assign bus.send_ring_wr_en = ring_wr;
  assign bus.send_fifo_data  = len_q;
  assign bus.send_fifo_wr_en = fifo_wr;
  assign bus.error           = error_q;
endmodule

// File: tb/tb_framing_send_arb.sv
// tb/tb_framing_send_arb.sv - directed vector bench for framing_send_arb
module tb_framing_send_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  framing_send_arb_if #(.NREQ(4), .LEN_BITS(8)) bus ();

  framing_send_arb #(.NREQ(4), .LEN_BITS(8), .MAX_PAYLOAD(58)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] lens;
    logic [7:0]  order;
    int          fs, fl, ffs, ffl, gap_at, clr_at;
    int          first_wr, done_cyc, nwr, nfifo;
    logic        err;
  } vec_t;

  vec_t        tbl [15];
  vec_t        cv;
  int          errors = 0;
  int          checks = 0;
  int          vi = 0;
  int          cyc = 0;
  logic [3:0]  pending;
  int          ptr [4];
  logic [31:0] lens;
  int          m, wc, nwr, nfifo, first_wr, last_done, n_msgs;

  function automatic logic [7:0] byte_of(int i, int p);
    int v;
    v = 161 + 16 * i + p;
    return v[7:0];
  endfunction

  function automatic logic [3:0] oh(int i);
    return 4'b0001 << i;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d cyc=%0d got=%0h want=%0h", name, vi, cyc, act, exp);
    end
  endtask

  task automatic apply_inputs();
    int nc;
    nc = cyc + 1;
    bus.req_valid = pending;
    bus.req_len   = lens;
    for (int i = 0; i < 4; i++) begin
      bus.req_data[i*8 +: 8]  = byte_of(i, ptr[i]);
      bus.req_data_valid[i]   = pending[i] && (nc != cv.gap_at);
    end
    bus.send_ring_full = (cv.fl > 0) && (nc >= cv.fs) && (nc < cv.fs + cv.fl);
    bus.send_fifo_full = (cv.ffl > 0) && (nc >= cv.ffs) && (nc < cv.ffs + cv.ffl);
    bus.clr            = (nc == cv.clr_at);
  endtask

  task automatic observe();
    int         c;
    logic [3:0] exp_oh;
    logic [7:0] clen;
    logic       big;
    c      = (m < n_msgs) ? int'(cv.order[m*2 +: 2]) : 0;
    exp_oh = (m < n_msgs) ? oh(c) : 4'b0000;
    clen   = lens[c*8 +: 8];
    if (bus.grant != 4'b0000) chk("grant_owner", bus.grant, exp_oh);
    if (bus.send_ring_wr_en) begin
      chk("ring_full_gate", bus.send_ring_full, 0);
      chk("ring_data", bus.send_ring_data, byte_of(c, wc));
      wc++;
      nwr++;
      if (first_wr == 0) first_wr = cyc;
    end
    chk("data_ack", bus.req_data_ack, bus.send_ring_wr_en ? exp_oh : 4'b0000);
    if (bus.req_err && bus.req_done == 4'b0000) chk("err_without_done", bus.req_err, 0);
    if (bus.send_fifo_wr_en) begin
      nfifo++;
      chk("fifo_after_ring", bus.send_ring_wr_en, 0);
      chk("fifo_data", bus.send_fifo_data, clen);
      chk("fifo_after_bytes", wc, clen);
    end
    if (bus.req_done != 4'b0000) begin
      if (m >= n_msgs) chk("extra_done", bus.req_done, 0);
      else begin
        big = (clen > 8'd58);
        chk("done_owner", bus.req_done, exp_oh);
        chk("req_err", bus.req_err, big);
        chk("fifo_with_done", bus.send_fifo_wr_en, !big);
        last_done = cyc;
        m++;
        wc = 0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.req_data_ack[i]) ptr[i]++;
      if (bus.req_done[i]) pending[i] = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    observe();
    @(posedge clk);
    #1;
    apply_inputs();
  endtask

  task automatic load(vec_t v);
    cv = v;
    vi++;
    lens = v.lens;
    pending = v.mask;
    for (int i = 0; i < 4; i++) ptr[i] = 0;
    m = 0; wc = 0; nwr = 0; nfifo = 0; first_wr = 0; last_done = 0;
    n_msgs = $countones(v.mask);
  endtask

  // Reset is held with the requests already presented; release happens just
  // after a rising edge so the following cycle is cycle 1 of the vector.
  task automatic reset_dut();
    rst_n = 1'b0;
    cyc = 0;
    apply_inputs();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_strobes", {bus.req_data_ack, bus.req_done, bus.req_err,
                        bus.send_ring_wr_en, bus.send_fifo_wr_en}, 0);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(vec_t v);
    int extra;
    load(v);
    reset_dut();
    extra = 0;
    while (extra < 3 && cyc < 300) begin
      step();
      if (pending == 4'b0000) extra++;
    end
    if (pending != 4'b0000) chk("timeout_pending", pending, 0);
    chk("msgs_done", m, n_msgs);
    chk("done_cycle", last_done, v.done_cyc);
    chk("first_ring_wr", first_wr, v.first_wr);
    chk("ring_writes", nwr, v.nwr);
    chk("fifo_writes", nfifo, v.nfifo);
    chk("error_flag", bus.error, v.err);
  endtask

  initial begin
    int nf;
    //           mask     lens          order fs fl ffs ffl gap clr first done nwr nfifo err
    tbl[0]  = '{4'b0001, 32'h00000003, 8'h00, 0, 0, 0, 0, 0, 0, 2, 5,  3,  1, 1'b0};
    tbl[1]  = '{4'b0110, 32'h00020200, 8'h09, 0, 0, 0, 0, 0, 0, 2, 8,  4,  2, 1'b0};
    tbl[2]  = '{4'b0001, 32'h00000004, 8'h00, 4, 5, 0, 0, 0, 0, 2, 11, 4,  1, 1'b0};
    tbl[3]  = '{4'b0001, 32'h00000000, 8'h00, 0, 0, 0, 0, 0, 0, 0, 2,  0,  1, 1'b0};
    tbl[4]  = '{4'b1000, 32'h3C000000, 8'h03, 0, 0, 0, 0, 0, 0, 0, 2,  0,  0, 1'b1};
    tbl[5]  = '{4'b1000, 32'h3C000000, 8'h03, 0, 0, 0, 0, 0, 2, 0, 2,  0,  0, 1'b1};
    tbl[6]  = '{4'b1000, 32'h3C000000, 8'h03, 0, 0, 0, 0, 0, 3, 0, 2,  0,  0, 1'b0};
    tbl[7]  = '{4'b0100, 32'h003A0000, 8'h02, 0, 0, 0, 0, 0, 0, 2, 60, 58, 1, 1'b0};
    tbl[8]  = '{4'b0001, 32'h0000003B, 8'h00, 0, 0, 0, 0, 0, 0, 0, 2,  0,  0, 1'b1};
    tbl[9]  = '{4'b1111, 32'h01010101, 8'hE4, 0, 0, 0, 0, 0, 0, 2, 12, 4,  4, 1'b0};
    tbl[10] = '{4'b0010, 32'h00000200, 8'h01, 0, 0, 4, 3, 0, 0, 2, 7,  2,  1, 1'b0};
    tbl[11] = '{4'b1011, 32'h01003C02, 8'h34, 0, 0, 0, 0, 0, 0, 2, 9,  3,  2, 1'b1};
    tbl[12] = '{4'b0001, 32'h00000003, 8'h00, 0, 0, 0, 0, 3, 0, 2, 6,  3,  1, 1'b0};
    tbl[13] = '{4'b0001, 32'h00000001, 8'h00, 2, 2, 0, 0, 0, 0, 4, 5,  1,  1, 1'b0};
    tbl[14] = '{4'b1001, 32'h01000001, 8'h0C, 0, 0, 0, 0, 0, 0, 2, 6,  2,  2, 1'b0};

    for (int t = 0; t < 15; t++) run_vec(tbl[t]);

    // Reset dropped in the middle of a copy: outputs fall at once, no length write follows.
    load('{4'b0001, 32'h00000005, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0});
    reset_dut();
    step();
    step();
    step();
    chk("copy_active_before_reset", bus.send_ring_wr_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", bus.grant, 0);
    chk("async_rst_strobes", {bus.req_data_ack, bus.req_done, bus.req_err,
                              bus.send_ring_wr_en, bus.send_fifo_wr_en}, 0);
    pending = 4'b0000;
    apply_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nf = nfifo;
    for (int k = 0; k < 6; k++) step();
    chk("no_fifo_after_reset", nfifo - nf, 0);
    chk("no_done_after_reset", m, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
